// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared FSM encoding and default starvation limit for the SRAM port arbiter
package sram_port_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_DM = 2'd2
    } state_e;
    localparam int STARVE_LIMIT_DEFAULT = 4;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch, data and SRAM-side signals of the shared single-port SRAM
interface sram_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    modport slave (
        input  if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, sram_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, sram_en, sram_wen, sram_addr, sram_wdata
    );
    modport master (
        output if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, sram_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter_starve_counter.sv
// starve_counter: saturating count of data grants taken while a fetch was waiting
module starve_counter
    import sram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign sat = cnt_q == W'(LIMIT);
    always_comb cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between fetch and load/store, data first with anti-starvation
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    sram_port_arbiter_if.slave bus
);
    state_e state_q, state_d;
    logic   sat, idle, grant_if, grant_dm;
    // Reset gates everything combinationally so an in-flight ack is dropped, not deferred
    assign idle     = !rst && state_q == IDLE;
    assign grant_dm = idle && bus.dm_req && !(sat && bus.if_req);
    assign grant_if = idle && bus.if_req && !grant_dm;
    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (grant_dm && bus.if_req),
        .clr (grant_if || (grant_dm && !bus.if_req)),
        .sat (sat)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d        = grant_dm ? RESP_DM : grant_if ? RESP_IF : IDLE;
        bus.sram_en    = grant_dm || grant_if;
        bus.sram_wen   = grant_dm ? bus.dm_wen : 4'b0000;
        bus.sram_addr  = grant_dm ? bus.dm_addr : grant_if ? bus.if_addr : 32'd0;
        bus.sram_wdata = grant_dm ? bus.dm_wdata : 32'd0;
        bus.if_ack     = !rst && state_q == RESP_IF;
        bus.dm_ack     = !rst && state_q == RESP_DM;
        bus.if_rdata   = bus.if_ack ? bus.sram_rdata : 32'd0;
        bus.dm_rdata   = bus.dm_ack ? bus.sram_rdata : 32'd0;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if bus();

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [31:0] sr);
        @(negedge clk);
        rst            = r;
        bus.if_req     = ir;
        bus.if_addr    = ia;
        bus.dm_req     = dr;
        bus.dm_wen     = dw;
        bus.dm_addr    = da;
        bus.dm_wdata   = dd;
        bus.sram_rdata = sr;
        #1;
    endtask

    function automatic logic [134:0] outs();
        return {bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata,
                bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'h100, 1, 4'hF, 32'h200, 32'h55, 32'h1234);
            checks++;
            if (outs() !== 135'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got %h want 0", i, outs());
            end
        end
    endtask

    task automatic test_fetch();
        drive(0, 1, 32'h100, 0, 4'hF, 32'h300, 32'h77, 32'h0);
        checks++;
        if ({bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.if_ack, bus.dm_ack} !==
            {1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fetch_issue got en=%b wen=%h addr=%h wd=%h ia=%b da=%b want 1 0 100 0 0 0",
                     bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.if_ack, bus.dm_ack);
        end
        drive(0, 1, 32'h100, 0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
        checks++;
        if ({bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.sram_en} !==
            {1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL fetch_resp got ia=%b ird=%h da=%b drd=%h en=%b want 1 deadbeef 0 0 0",
                     bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.sram_en);
        end
        drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (outs() !== 135'd0) begin
            failures++;
            $display("FAIL idle_no_req got %h want 0", outs());
        end
    endtask

    task automatic test_store();
        drive(0, 0, 32'h0, 1, 4'b0100, 32'h202, 32'h00AB0000, 32'h0);
        checks++;
        if ({bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata} !==
            {1'b1, 4'b0100, 32'h202, 32'h00AB0000}) begin
            failures++;
            $display("FAIL store_issue got en=%b wen=%h addr=%h wd=%h want 1 4 202 00ab0000",
                     bus.sram_en, bus.sram_wen, bus.sram_addr, bus.sram_wdata);
        end
        drive(0, 0, 32'h0, 1, 4'b0100, 32'h202, 32'h00AB0000, 32'hCAFEF00D);
        checks++;
        if ({bus.dm_ack, bus.dm_rdata, bus.if_ack, bus.if_rdata, bus.sram_en} !==
            {1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL store_resp got da=%b drd=%h ia=%b ird=%h en=%b want 1 cafef00d 0 0 0",
                     bus.dm_ack, bus.dm_rdata, bus.if_ack, bus.if_rdata, bus.sram_en);
        end
    endtask

    task automatic test_starve();
        bit exp_dm [6] = '{1, 1, 1, 1, 0, 1};
        drive(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        for (int g = 0; g < 6; g++) begin
            drive(0, 1, 32'h400, 1, 4'h3, 32'h800, 32'h11, 32'h0);
            checks++;
            if ({bus.sram_en, bus.sram_addr} !== {1'b1, exp_dm[g] ? 32'h800 : 32'h400}) begin
                failures++;
                $display("FAIL starve_grant %0d got en=%b addr=%h want en=1 addr=%h",
                         g, bus.sram_en, bus.sram_addr, exp_dm[g] ? 32'h800 : 32'h400);
            end
            drive(0, 1, 32'h400, 1, 4'h3, 32'h800, 32'h11, 32'(g + 1));
            checks++;
            if ({bus.if_ack, bus.dm_ack, bus.sram_en} !== {!exp_dm[g], exp_dm[g], 1'b0}) begin
                failures++;
                $display("FAIL starve_ack %0d got ia=%b da=%b en=%b want %b %b 0",
                         g, bus.if_ack, bus.dm_ack, bus.sram_en, !exp_dm[g], exp_dm[g]);
            end
        end
    endtask

    task automatic test_reset_in_resp();
        drive(0, 0, 32'h0, 1, 4'h0, 32'h900, 32'h0, 32'h0);
        drive(1, 0, 32'h0, 1, 4'h0, 32'h900, 32'h0, 32'h99);
        checks++;
        if (outs() !== 135'd0) begin
            failures++;
            $display("FAIL reset_in_resp got %h want 0", outs());
        end
        drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h99);
        checks++;
        if (outs() !== 135'd0) begin
            failures++;
            $display("FAIL aborted_ack_late got %h want 0", outs());
        end
        drive(0, 0, 32'h0, 1, 4'h0, 32'hA00, 32'h0, 32'h0);
        checks++;
        if ({bus.sram_en, bus.sram_addr, bus.dm_ack} !== {1'b1, 32'hA00, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_issue got en=%b addr=%h da=%b want 1 a00 0",
                     bus.sram_en, bus.sram_addr, bus.dm_ack);
        end
        drive(0, 0, 32'h0, 1, 4'h0, 32'hA00, 32'h0, 32'h42);
        checks++;
        if ({bus.dm_ack, bus.dm_rdata} !== {1'b1, 32'h42}) begin
            failures++;
            $display("FAIL post_reset_ack got da=%b drd=%h want 1 42", bus.dm_ack, bus.dm_rdata);
        end
    endtask

    task automatic test_drop();
        drive(0, 0, 32'h0, 1, 4'h0, 32'hB00, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h5A5A);
        checks++;
        if ({bus.dm_ack, bus.dm_rdata, bus.if_ack} !== {1'b1, 32'h5A5A, 1'b0}) begin
            failures++;
            $display("FAIL drop_ack got da=%b drd=%h ia=%b want 1 5a5a 0",
                     bus.dm_ack, bus.dm_rdata, bus.if_ack);
        end
        drive(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h5A5A);
        checks++;
        if (outs() !== 135'd0) begin
            failures++;
            $display("FAIL drop_idle got %h want 0", outs());
        end
    endtask

    task automatic test_random();
        bit          m_busy = 0, m_dm = 0, pick_dm;
        int          m_starve = 0;
        logic        r, ir = 0, dr = 0;
        logic [31:0] ia = 0, da = 0, dd = 0, sr;
        logic [3:0]  dw = 0;
        logic        e_ia, e_da, e_en;
        logic [31:0] e_ir, e_dr, e_a, e_wd;
        logic [3:0]  e_w;
        drive(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 49) == 0;
            if (!ir) begin
                ir = $urandom_range(0, 2) != 0;
                ia = $urandom;
            end else if ($urandom_range(0, 39) == 0) ir = 0;
            if (!dr) begin
                dr = $urandom_range(0, 2) != 0;
                da = $urandom;
                dd = $urandom;
                dw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end else if ($urandom_range(0, 39) == 0) dr = 0;
            sr = $urandom;
            drive(r, ir, ia, dr, dw, da, dd, sr);
            {e_ia, e_da, e_en, e_ir, e_dr, e_a, e_wd, e_w} = '0;
            if (r) begin
                m_busy   = 0;
                m_starve = 0;
            end else if (m_busy) begin
                if (m_dm) {e_da, e_dr} = {1'b1, sr};
                else      {e_ia, e_ir} = {1'b1, sr};
                m_busy = 0;
            end else if (ir || dr) begin
                pick_dm = dr && !(ir && m_starve == LIMIT);
                e_en = 1;
                if (pick_dm) begin
                    {e_w, e_a, e_wd} = {dw, da, dd};
                    m_starve = ir ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                end else begin
                    e_a      = ia;
                    m_starve = 0;
                end
                m_busy = 1;
                m_dm   = pick_dm;
            end
            checks++;
            if (outs() !== {e_ia, e_ir, e_da, e_dr, e_en, e_w, e_a, e_wd}) begin
                failures++;
                $display("FAIL random cycle %0d got %h want %h", c, outs(),
                         {e_ia, e_ir, e_da, e_dr, e_en, e_w, e_a, e_wd});
            end
            if (e_ia || r) ir = 0;
            if (e_da || r) dr = 0;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_reset_in_resp();
        test_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while fetch waits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  fetch request; held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch word address; held with if_req.
REQ-006 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  32  fetch data, valid while if_ack=1.
REQ-008 SHALL have port dm_req  input  1  load/store request; held until dm_ack.
REQ-009 SHALL have port dm_wen  input  4  byte-lane write enables, already lane-aligned; 0 = load.
REQ-010 SHALL have port dm_addr  input  32  data address; held with dm_req.
REQ-011 SHALL have port dm_wdata  input  32  store data, already lane-shifted.
REQ-012 SHALL have port dm_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port dm_rdata  output  32  raw SRAM word, valid while dm_ack=1.
REQ-014 SHALL have port sram_en  output  1  SRAM access strobe.
REQ-015 SHALL have port sram_wen  output  4  SRAM byte write enables.
REQ-016 SHALL have port sram_addr  output  32  SRAM address.
REQ-017 SHALL have port sram_wdata  output  32  SRAM write data.
REQ-018 SHALL have port sram_rdata  input  32  SRAM read data, valid one cycle after sram_en.

Function
REQ-019 SHALL implement FSM states IDLE, RESP_IF, RESP_DM.
REQ-020 In IDLE with any request: issue cycle N, sram_en=1 combinationally, selected requester's addr/wen/wdata driven to SRAM; next state RESP_IF or RESP_DM.
REQ-021 Fetch issue SHALL drive sram_wen=4'b0000 and sram_wdata=0.
REQ-022 In IDLE with no request: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0; stay IDLE.
REQ-023 Cycle N+1 (RESP_x): ack pulses for granted side only, rdata=sram_rdata; sram_en=0; return to IDLE.
REQ-024 Latency 1 cycle issue-to-ack; throughput one access per 2 cycles; response state never issues.
REQ-025 Ack SHALL pulse in RESP_x even if the requester dropped req; the access has committed.
REQ-026 Non-granted if_rdata/dm_rdata SHALL read 0; if_ack and dm_ack never both 1.
REQ-027 Priority: dm_req beats if_req, except when starvation counter equals STARVE_LIMIT.
REQ-028 Counter (width clog2(STARVE_LIMIT+1)) increments on each DM grant issued while if_req=1, saturating at STARVE_LIMIT.
REQ-029 Counter clears on every IF grant and on any DM grant issued with if_req=0.
REQ-030 At counter==STARVE_LIMIT with both requests: grant IF, clear counter.

Reset
REQ-031 rst=1 at an edge: state IDLE, counter 0, regardless of current state.
REQ-032 Reset outputs: all acks 0, all rdata 0, sram_en 0, sram_wen 0, sram_addr 0, sram_wdata 0.
REQ-033 Reset in RESP_x SHALL drop that ack; no ack appears afterwards for the aborted access.
REQ-034 While rst=1, no request SHALL be granted.

Structure
REQ-035 Shared package SHALL hold the state encoding (IDLE=2'd0, RESP_IF=2'd1, RESP_DM=2'd2) and STARVE_LIMIT default.
REQ-036 Starvation counter SHALL be sub-module starve_counter (inc, clr, sat output).
REQ-037 Byte-lane alignment and load extension SHALL remain outside this block.

Verification
REQ-038 if_req, if_addr=0x100, sram_rdata=0xDEADBEEF next cycle -> sram_en=1,addr=0x100,wen=0 at N; if_ack=1, if_rdata=0xDEADBEEF at N+1.
REQ-039 dm_req, dm_wen=4'b0100, addr=0x202, wdata=0x00AB0000 -> SRAM sees same at N; dm_ack at N+1; no if_ack.
REQ-040 Both requesting continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM... acks every other cycle.
REQ-041 rst asserted in RESP_DM -> dm_ack=0 that cycle, all outputs 0, state IDLE next.
REQ-042 dm_req dropped during RESP_DM -> dm_ack still 1 at N+1; IDLE with no issue afterwards.
